// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, CR/SR layouts and FSM states shared by uart_reg_bridge.
package uart_pkg;
  localparam int UART_CR_OFFSET    = 0;
  localparam int UART_SR_OFFSET    = 1;
  localparam int UART_DINL_OFFSET  = 2;
  localparam int UART_DINH_OFFSET  = 3;
  localparam int UART_DOUTL_OFFSET = 4;
  localparam int UART_DOUTM_OFFSET = 5;
  localparam int UART_DOUTH_OFFSET = 6;
  typedef struct packed {
    logic [2:0] rsvd;
    logic       enable;
    logic       cmd_err;
    logic       res_overflow;
    logic       res_full;
    logic       res_empty;
  } uart_sr_t;
  typedef struct packed {
    logic [4:0] rsvd;
    logic       clr_err;
    logic       flush;
    logic       enable;
  } uart_cr_t;
  typedef enum logic [1:0] {IDLE, WDATA, RRESP} bridge_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; a push into a full FIFO succeeds only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign empty = cnt_q == '0;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign dout  = mem_q[rd_q];
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: UART byte stream to register bridge feeding ECG samples in and R-peak results out.
// Define UART_REG_BRIDGE_TIMEOUT_EN to abandon a write whose data byte never arrives.
module uart_reg_bridge
  import uart_pkg::*;
#(
  parameter int ADDR_WIDTH     = 3,
  parameter int SAMPLE_WIDTH   = 11,
  parameter int RESULT_WIDTH   = 22,
  parameter int RES_DEPTH      = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [SAMPLE_WIDTH-1:0] sample_data,
  output logic                    sample_valid,
  input  logic [RESULT_WIDTH-1:0] result_data,
  input  logic                    result_valid,
  output logic                    enable
);
  localparam int DIN_BYTES  = (SAMPLE_WIDTH + 7) / 8;
  localparam int DOUT_BYTES = (RESULT_WIDTH + 7) / 8;
  localparam int DIN_BASE   = UART_DINL_OFFSET;
  localparam int DOUT_BASE  = DIN_BASE + DIN_BYTES;
  localparam int DIN_TOP    = DOUT_BASE - 1;
  localparam int DOUT_TOP   = DOUT_BASE + DOUT_BYTES - 1;
  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 7 || DOUT_TOP >= (1 << ADDR_WIDTH) || TIMEOUT_CYCLES < 1)
    begin : g_bad_cfg
      $error("uart_reg_bridge: register map does not fit the address field");
    end
  bridge_state_t state_q, state_d;
  uart_cr_t cr_q, cr_d;
  uart_sr_t sr;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, cmd_addr;
  logic [7:0] tx_data_q, tx_data_d, rd_byte;
  logic [DIN_BYTES*8-1:0] din_q, din_d;
  logic [DOUT_BYTES*8-1:0] shadow_q, shadow_d, shadow_rd, head;
  logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
  logic sv_q, sv_d, ovf_q, ovf_d, err_q, err_d;
  logic cmd_ok, timeout;
  logic [RESULT_WIDTH-1:0] fifo_dout;
  logic fifo_full, fifo_empty, fifo_pop;
  sync_fifo #(.WIDTH(RESULT_WIDTH), .DEPTH(RES_DEPTH)) u_res_fifo (
    .clk(clk), .rst(rst || cr_q.flush), .push(result_valid), .pop(fifo_pop),
    .din(result_data), .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty)
  );
`ifdef UART_REG_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  always_comb begin
    to_cnt_d = (state_q == WDATA && !rx_valid) ? to_cnt_q + 1'b1 : '0;
    timeout  = state_q == WDATA && !rx_valid && to_cnt_q == TW'(TIMEOUT_CYCLES - 1);
  end
  always_ff @(posedge clk) to_cnt_q <= rst ? '0 : to_cnt_d;
`else
  assign timeout = 1'b0;
`endif
  assign cmd_addr     = rx_data[ADDR_WIDTH:1];
  assign cmd_ok       = (rx_data >> (ADDR_WIDTH + 1)) == 8'h00;
  assign tx_data      = tx_data_q;
  assign tx_valid     = state_q == RRESP;
  assign enable       = cr_q.enable;
  assign sample_data  = sample_q;
  assign sample_valid = sv_q;
  // Reading DOUT byte 0 snapshots the FIFO head so later bytes come from one entry.
  always_comb begin
    head = '0;
    head[RESULT_WIDTH-1:0] = fifo_empty ? '0 : fifo_dout;
    shadow_rd = (cmd_addr == ADDR_WIDTH'(DOUT_BASE)) ? head : shadow_q;
    sr = '0;
    sr.enable       = cr_q.enable;
    sr.cmd_err      = err_q;
    sr.res_overflow = ovf_q;
    sr.res_full     = fifo_full;
    sr.res_empty    = fifo_empty;
    rd_byte = 8'h00;
    if (cmd_addr == ADDR_WIDTH'(UART_CR_OFFSET)) rd_byte = cr_q;
    if (cmd_addr == ADDR_WIDTH'(UART_SR_OFFSET)) rd_byte = sr;
    for (int i = 0; i < DIN_BYTES; i++)
      if (cmd_addr == ADDR_WIDTH'(DIN_BASE + i)) rd_byte = din_q[i*8 +: 8];
    for (int i = 0; i < DOUT_BYTES; i++)
      if (cmd_addr == ADDR_WIDTH'(DOUT_BASE + i)) rd_byte = shadow_rd[i*8 +: 8];
  end
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    tx_data_d  = tx_data_q;
    din_d      = din_q;
    sample_d   = sample_q;
    sv_d       = 1'b0;
    shadow_d   = shadow_q;
    fifo_pop   = 1'b0;
    cr_d       = cr_q;
    cr_d.flush   = 1'b0;
    cr_d.clr_err = 1'b0;
    err_d      = err_q && !cr_q.clr_err;
    case (state_q)
      IDLE: if (rx_valid) begin
        if (!cmd_ok) err_d = 1'b1;
        else if (rx_data[0]) begin
          addr_d  = cmd_addr;
          state_d = WDATA;
        end else begin
          tx_data_d = rd_byte;
          state_d   = RRESP;
          if (cmd_addr == ADDR_WIDTH'(DOUT_BASE)) shadow_d = shadow_rd;
          if (cmd_addr == ADDR_WIDTH'(DOUT_TOP)) fifo_pop = !fifo_empty;
        end
      end
      WDATA: if (rx_valid) begin
        state_d = IDLE;
        if (addr_q == ADDR_WIDTH'(UART_CR_OFFSET)) cr_d = uart_cr_t'({5'b0, rx_data[2:0]});
        for (int i = 0; i < DIN_BYTES; i++)
          if (addr_q == ADDR_WIDTH'(DIN_BASE + i)) din_d[i*8 +: 8] = rx_data;
        if (addr_q == ADDR_WIDTH'(DIN_TOP) && cr_q.enable) begin
          sample_d = din_d[SAMPLE_WIDTH-1:0];
          sv_d     = 1'b1;
        end
      end else if (timeout) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end
      RRESP: begin
        if (rx_valid) err_d = 1'b1;
        if (tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (cr_q.flush) shadow_d = '0;
    ovf_d = (ovf_q && !cr_q.clr_err) || (result_valid && fifo_full && !fifo_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cr_q      <= '0;
      tx_data_q <= '0;
      din_q     <= '0;
      sample_q  <= '0;
      sv_q      <= 1'b0;
      shadow_q  <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cr_q      <= cr_d;
      tx_data_q <= tx_data_d;
      din_q     <= din_d;
      sample_q  <= sample_d;
      sv_q      <= sv_d;
      shadow_q  <= shadow_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
    end
  end
endmodule
